sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001: Parameter AW, default 12, tile ROM address width.
REQ-002: Parameter DW, default 48, tile ROM data width (16 px x 3 bit).
REQ-003: Clk  input  1  single clock; all state rising-edge.
REQ-004: Reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005: En  input  1  1 = new grants allowed; 0 = drain only.
REQ-006: Frame_Start  input  1  one-cycle pulse at the start of each frame.
REQ-007: Req  input  3  request per requester (0 = map, 1 = player 1, 2 = player 2).
REQ-008: Addr0, Addr1, Addr2  input  AW each  request address, held stable while the matching Req is high.
REQ-009: Gnt  output  3  registered one-hot grant pulse.
REQ-010: Rom_Addr  output  AW  registered address to the synchronous tile ROM.
REQ-011: Rom_Data  input  DW  ROM output, valid one cycle after Rom_Addr.
REQ-012: Rd_Data  output  DW  combinational copy of Rom_Data.
REQ-013: Rd_Valid  output  3  registered one-hot; marks Rd_Data for that requester.
REQ-014: Busy  output  1  1 while any grant is in flight.
REQ-015: Grant_Count  output  16  grants issued since the last Frame_Start.

Function
REQ-016: Arbitration occurs every cycle over eligible = Req & ~Gnt, with all eligibility cleared when En = 0.
- A requester granted this cycle is masked for that cycle, which prevents a double grant on a held Req.
REQ-017: Selection is round-robin.
- Pointer P (0..2) is checked first, then P+1, then P+2, modulo 3.
- After a grant to i, P = (i+1) mod 3.
- With no grant, P holds.
REQ-018: When eligible is non-zero in cycle c, the edge ending cycle c registers three things:
- Gnt = one-hot(winner).
- Rom_Addr = Addr[winner].
- Stage-1 owner = winner, with valid = 1.
REQ-019: When eligible is zero, the next Gnt is 0, Rom_Addr holds its value, and stage-1 valid is 0.
REQ-020: Stage-1 owner and valid are registered into Rd_Valid, so Rd_Valid[winner] is 1 exactly in cycle c+2 and Rom_Data is valid in that same cycle.
REQ-021: Fixed latency from the request cycle: Gnt at c+1, Rd_Valid at c+2. There is no backpressure; a requester must accept data at c+2.
REQ-022: Requester protocol: Req stays high until Gnt is seen, then deasserts or presents a new address in the Gnt cycle. One grant equals one read.
REQ-023: Throughput:
- The arbiter issues at most one grant per cycle.
- A single requester holding Req continuously is granted every second cycle.
- Three requesters are each served once per 3 cycles.
REQ-024: Busy = stage-1 valid OR any Rd_Valid bit.
REQ-025: States are IDLE, ACTIVE and DRAIN.
- IDLE: no grant and no in-flight read. A grant moves to ACTIVE.
- ACTIVE: reads in flight with En = 1. En = 0 moves to DRAIN.
- DRAIN: no new grants; in-flight reads complete normally. Moves to IDLE once Busy = 0.
- With En = 1 in DRAIN, move to ACTIVE if eligible is non-zero, otherwise to IDLE once Busy = 0.
REQ-026: Frame_Start, with precedence over every other P update in the same cycle:
- resets P to 0;
- sets Grant_Count to 0, or to 1 if a grant occurs in the same cycle;
- does not cancel in-flight reads.
REQ-027: Grant_Count increments per grant and saturates at 16'hFFFF.
REQ-028: Request changes during DRAIN are ignored; a Req still high is arbitrated once En returns.

Reset
REQ-029: Reset = 0 forces, asynchronously:
- Gnt = 0, Rd_Valid = 0 and stage-1 valid = 0;
- Rom_Addr = 0, P = 0, Grant_Count = 0, Busy = 0;
- state = IDLE.
REQ-030: Reset asserted mid-transaction discards in-flight reads, so no Rd_Valid appears after release.
REQ-031: The first grant is possible in the first cycle after Reset deasserts.

Verification
REQ-032: Req=001, Addr0=12'h0A5 in cycle 0 -> Gnt=001 and Rom_Addr=0A5 in cycle 1; Rd_Valid=001 in cycle 2; Grant_Count=1.
REQ-033: Req=111 held for 6 cycles from P=0 -> Gnt sequence 001,010,100,001,010,100; Grant_Count=6.
REQ-034: Req=010 held constantly -> Gnt=010 on alternate cycles only; no consecutive grants.
REQ-035: Grant in cycle 0, En=0 from cycle 1 with Req=111 -> Rd_Valid for the cycle-0 grant at cycle 2; no further Gnt; Busy=0 and state IDLE by cycle 3.
REQ-036: Frame_Start coincident with a grant to requester 1 -> Grant_Count=1 and P=0 in the next cycle; in-flight Rd_Valid still delivered.
REQ-037: Reset pulsed low in the cycle after Gnt -> Rd_Valid never asserts; all outputs 0 until the next request.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Three-way round-robin arbiter in front of a synchronous tile ROM.
// A grant is issued one cycle after the request, and data returns one cycle after that.
module sprite_rom_arbiter #(
    parameter int AW = 12,
    parameter int DW = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          frame_start,
    input  logic [2:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    output logic [2:0]    gnt,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] rd_data,
    output logic [2:0]    rd_valid,
    output logic          busy,
    output logic [15:0]   grant_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t        state_reg;
    logic [1:0]    ptr_reg;
    logic          s1_valid_reg;
    logic [1:0]    s1_owner_reg;

    logic [2:0]    eligible;
    logic          grant_any;
    logic [1:0]    winner;
    logic [1:0]    ptr_after_win;
    logic [AW-1:0] sel_addr;
    logic          busy_next;

    // Masking with the current grant stops a held request from winning twice in a row.
    assign eligible  = en ? (req & ~gnt) : 3'b000;
    assign grant_any = |eligible;

    always_comb begin
        winner = 2'd0;
        case (ptr_reg)
            2'd1:    winner = eligible[1] ? 2'd1 : (eligible[2] ? 2'd2 : 2'd0);
            2'd2:    winner = eligible[2] ? 2'd2 : (eligible[0] ? 2'd0 : 2'd1);
            default: winner = eligible[0] ? 2'd0 : (eligible[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_addr = addr0;
        case (winner)
            2'd1:    sel_addr = addr1;
            2'd2:    sel_addr = addr2;
            default: sel_addr = addr0;
        endcase
    end

    assign ptr_after_win = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
    assign busy_next     = grant_any | s1_valid_reg;
    assign busy          = s1_valid_reg | (|rd_valid);
    assign rd_data       = rom_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt          <= 3'b000;
            rom_addr     <= '0;
            s1_valid_reg <= 1'b0;
            s1_owner_reg <= 2'd0;
            rd_valid     <= 3'b000;
            ptr_reg      <= 2'd0;
            grant_count  <= 16'd0;
            state_reg    <= IDLE;
        end else begin
            gnt          <= grant_any ? (3'b001 << winner) : 3'b000;
            s1_valid_reg <= grant_any;
            if (grant_any) begin
                rom_addr     <= sel_addr;
                s1_owner_reg <= winner;
            end
            rd_valid <= s1_valid_reg ? (3'b001 << s1_owner_reg) : 3'b000;

            // A frame boundary restarts fairness and counting but leaves reads in flight.
            if (frame_start) begin
                ptr_reg     <= 2'd0;
                grant_count <= {15'd0, grant_any};
            end else begin
                if (grant_any) begin
                    ptr_reg <= ptr_after_win;
                end
                if (grant_any && grant_count != 16'hFFFF) begin
                    grant_count <= grant_count + 16'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!en) begin
                        state_reg <= busy_next ? DRAIN : IDLE;
                    end else if (!busy_next) begin
                        state_reg <= IDLE;
                    end
                end
                DRAIN: begin
                    if (grant_any) begin
                        state_reg <= ACTIVE;
                    end else if (!busy_next) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: a cycle-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        frame_start;
    logic [2:0]  req;
    logic [11:0] addr0, addr1, addr2;
    logic [2:0]  gnt;
    logic [11:0] rom_addr;
    logic [47:0] rom_data;
    logic [47:0] rd_data;
    logic [2:0]  rd_valid;
    logic        busy;
    logic [15:0] grant_count;

    int errors = 0;
    int checks = 0;

    sprite_rom_arbiter #(.AW(12), .DW(48)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
        .req(req), .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rom_fn(input logic [11:0] a);
        return {a, ~a, a ^ 12'h5A5, a + 12'd1};
    endfunction

    // Synchronous tile ROM: data one cycle after the address.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one grant per cycle picked round-robin among requesters not granted
    // last cycle; grant visible the next cycle, data one cycle after that.
    logic [2:0]  m_gnt, m_rdv;
    logic [11:0] m_addr, m_data_addr;
    logic        m_s1v;
    int          m_s1o, m_p, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gnt <= 3'b000; m_rdv <= 3'b000; m_addr <= 12'd0; m_data_addr <= 12'd0;
            m_s1v <= 1'b0; m_s1o <= 0; m_p <= 0; m_cnt <= 0;
        end else begin : model_step
            logic [2:0] el;
            bit         found;
            int         w;
            el = en ? (req & ~m_gnt) : 3'b000;
            found = 0;
            w = 0;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (m_p + k) % 3;
                if (!found && el[idx]) begin
                    found = 1;
                    w = idx;
                end
            end
            m_gnt <= found ? 3'(1 << w) : 3'b000;
            m_s1v <= found;
            if (found) begin
                m_s1o  <= w;
                m_addr <= (w == 0) ? addr0 : ((w == 1) ? addr1 : addr2);
            end
            m_rdv <= m_s1v ? 3'(1 << m_s1o) : 3'b000;
            if (m_s1v) m_data_addr <= m_addr;
            if (frame_start) begin
                m_p   <= 0;
                m_cnt <= found ? 1 : 0;
            end else if (found) begin
                m_p   <= (w + 1) % 3;
                m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt", 64'(gnt), 64'(m_gnt));
            chk("rom_addr", 64'(rom_addr), 64'(m_addr));
            chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
            chk("busy", 64'(busy), 64'(m_s1v | (|m_rdv)));
            chk("grant_count", 64'(grant_count), 64'(m_cnt));
            if (m_rdv != 3'b000) begin
                chk("rd_data", 64'(rd_data), 64'(rom_fn(m_data_addr)));
                $display("txn t=%0t owner=%b addr=%h data=%h", $time, rd_valid, m_data_addr, rd_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] seq [6];
    logic [2:0] exp_seq [6];
    int         ngr, consec;
    logic       prev_g;

    initial begin
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_n = 1'b0; en = 1'b1; frame_start = 1'b0; req = 3'b000;
        addr0 = 12'd0; addr1 = 12'd0; addr2 = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(grant_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single read from the map requester.
        req = 3'b001; addr0 = 12'h0A5;
        tick();
        chk("t1_gnt", 64'(gnt), 64'h1);
        chk("t1_rom_addr", 64'(rom_addr), 64'h0A5);
        req = 3'b000;
        tick();
        chk("t1_rd_valid", 64'(rd_valid), 64'h1);
        chk("t1_rd_data", 64'(rd_data), 64'(rom_fn(12'h0A5)));
        chk("t1_count", 64'(grant_count), 64'd1);
        repeat (2) tick();

        // All three requesting from pointer 0.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        req = 3'b111; addr0 = 12'h111; addr1 = 12'h222; addr2 = 12'h333;
        for (int i = 0; i < 6; i++) begin
            tick();
            seq[i] = gnt;
        end
        req = 3'b000;
        for (int i = 0; i < 6; i++) chk("t2_gnt_seq", 64'(seq[i]), 64'(exp_seq[i]));
        chk("t2_count", 64'(grant_count), 64'd6);
        repeat (3) tick();

        // One requester holding its request: grants on alternate cycles.
        req = 3'b010; addr1 = 12'h2A0;
        ngr = 0; consec = 0; prev_g = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt == 3'b010) ngr++;
            if (gnt[1] && prev_g) consec++;
            prev_g = gnt[1];
        end
        req = 3'b000;
        chk("t3_grants", 64'(ngr), 64'd4);
        chk("t3_consecutive", 64'(consec), 64'd0);
        repeat (3) tick();

        // Drain: grant, then enable dropped with everyone requesting.
        req = 3'b001; addr0 = 12'h123;
        tick();
        chk("t4_gnt", 64'(gnt), 64'h1);
        en = 1'b0; req = 3'b111;
        tick();
        chk("t4_rd_valid", 64'(rd_valid), 64'h1);
        chk("t4_no_gnt_c2", 64'(gnt), 64'd0);
        tick();
        chk("t4_busy_c3", 64'(busy), 64'd0);
        chk("t4_no_gnt_c3", 64'(gnt), 64'd0);
        tick();
        chk("t4_no_gnt_c4", 64'(gnt), 64'd0);
        en = 1'b1; req = 3'b010;
        tick();
        chk("t4_resume_gnt", 64'(gnt), 64'h2);
        req = 3'b000;
        repeat (3) tick();

        // Frame start coinciding with a grant to player 1.
        req = 3'b010; addr1 = 12'h0F0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; req = 3'b000;
        chk("t5_gnt", 64'(gnt), 64'h2);
        chk("t5_count", 64'(grant_count), 64'd1);
        tick();
        chk("t5_rd_valid", 64'(rd_valid), 64'h2);
        req = 3'b111;
        tick();
        chk("t5_ptr_zero", 64'(gnt), 64'h1);
        req = 3'b000;
        repeat (3) tick();

        // Reset in the cycle after a grant drops the read.
        req = 3'b100; addr2 = 12'h3C3;
        tick();
        chk("t6_gnt", 64'(gnt), 64'h4);
        req = 3'b000;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 64'(gnt), 64'd0);
        chk("t6_rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_count", 64'(grant_count), 64'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_rd_valid", 64'(rd_valid), 64'd0);
            chk("t6_no_gnt", 64'(gnt), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
